// File: rtl/wide_fmt_pkg.sv
// wide_fmt_pkg: shared types, ASCII constants and digit-count helper for the decimal formatter
package wide_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    // Decimal digits needed for a width-bit unsigned value (log10(2) ~ 0.30103, rounded up)
    function automatic int ndig(input int width);
        return int'((longint'(width) * 64'sd30103 + 64'sd99999) / 64'sd100000);
    endfunction

endpackage

// File: rtl/wide_dec_dabble.sv
// wide_dec_dabble: add-3 correction over every BCD digit ahead of a double-dabble shift
module wide_dec_dabble #(
    parameter int NDIG = 20
) (
    input  logic [4*NDIG-1:0] bcd_i,
    output logic [4*NDIG-1:0] bcd_o
);

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        assign bcd_o[4*d +: 4] = (bcd_i[4*d +: 4] >= 4'd5) ? bcd_i[4*d +: 4] + 4'd3 : bcd_i[4*d +: 4];
    end

endmodule

// File: rtl/wide_dec_fmt.sv
// wide_dec_fmt: streams a WIDTH-bit value as decimal ASCII, one character per handshake
module wide_dec_fmt
    import wide_fmt_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_pad,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);

    localparam int NDIG = ndig(WIDTH);
    localparam int BW   = 4 * NDIG;
    localparam int PW   = $clog2(NDIG + 1);
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] POS_SIGN = PW'(NDIG);
    localparam logic [PW-1:0] POS_MSD  = PW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             pad_q, pad_d;
    logic             sgn_q, sgn_d;
    logic             seen_q, seen_d;
    logic             minus_q, minus_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_char_q, out_char_d;
    logic             out_last_q, out_last_d;

    logic [BW-1:0] dab, bcd_c, src, src_sh;
    logic [3:0]    cur, nxt;
    logic          at_sign, lead, fin, step, hold_pos;

    wide_dec_dabble #(.NDIG(NDIG)) u_dabble (
        .bcd_i(bcd_q),
        .bcd_o(dab)
    );

    // The final CONV edge already emits the first character, so the emit view reads the freshly shifted BCD then.
    // The digit under the cursor is always the top nibble; the sign column sees a virtual zero.
    assign bcd_c    = (dab << 1) | BW'(shreg_q[WIDTH-1]);
    assign src      = (state_q == CONV) ? bcd_c : bcd_q;
    assign src_sh   = src << 4;
    assign at_sign  = pos_q == POS_SIGN;
    assign cur      = at_sign ? 4'h0 : src[BW-1 -: 4];
    assign nxt      = at_sign ? src[BW-1 -: 4] : src_sh[BW-1 -: 4];
    assign lead     = !seen_q && cur == 4'h0 && pos_q != '0;
    assign fin      = out_valid_q && out_ready && out_last_q;
    assign step     = (state_q == CONV && cnt_q == CW'(1)) || (state_q == EMIT && (!out_valid_q || out_ready) && !fin);
    assign hold_pos = !pad_q && !lead && neg_q && !minus_q;

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;

    // Next-state: accept, one dabble shift per CONV cycle, one digit position per free EMIT slot
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        neg_d       = neg_q;
        pad_d       = pad_q;
        sgn_d       = sgn_q;
        seen_d      = seen_q;
        minus_d     = minus_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: if (in_valid) begin
                neg_d   = in_signed && in_data[WIDTH-1];
                shreg_d = (in_signed && in_data[WIDTH-1]) ? -in_data : in_data;
                pad_d   = in_pad;
                sgn_d   = in_signed;
                bcd_d   = '0;
                cnt_d   = CNT_FULL;
                pos_d   = (in_pad && in_signed) ? POS_SIGN : POS_MSD;
                seen_d  = 1'b0;
                minus_d = 1'b0;
                state_d = CONV;
            end
            CONV: begin
                shreg_d = shreg_q << 1;
                bcd_d   = bcd_c;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? EMIT : CONV;
            end
            EMIT: if (fin) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (step) begin
            seen_d      = seen_q || !lead;
            minus_d     = minus_q || hold_pos;
            out_valid_d = pad_q || !lead;
            out_char_d  = hold_pos ? CH_MINUS :
                          !lead    ? (CH_0 | {4'h0, cur}) :
                          (neg_q && (nxt != 4'h0 || pos_q == PW'(1))) ? CH_MINUS : CH_SP;
            out_last_d  = !hold_pos && pos_q == '0;
            if (!hold_pos) begin
                pos_d = pos_q - PW'(1);
                bcd_d = at_sign ? src : src_sh;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            pos_q       <= '0;
            neg_q       <= 1'b0;
            pad_q       <= 1'b0;
            sgn_q       <= 1'b0;
            seen_q      <= 1'b0;
            minus_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            pad_q       <= pad_d;
            sgn_q       <= sgn_d;
            seen_q      <= seen_d;
            minus_q     <= minus_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_wide_dec_fmt.sv
// tb_wide_dec_fmt: table, directed and randomized checks of the decimal formatter at WIDTH 8, 64 and 4096
module tb_wide_dec_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_l;
    logic [4095:0] td;
    logic          iv, pad, sgn, ordy;
    int            sel;

    logic       r8, r64, r4k, v8, v64, v4k, l8, l64, l4k, b8, b64, b4k;
    logic [7:0] c8, c64, c4k;
    logic       o_rdy, o_valid, o_last, o_busy;
    logic [7:0] o_char;

    int n_tests = 0;
    int n_fail  = 0;

    wide_dec_fmt #(.WIDTH(8)) u8 (
        .clk(clk), .reset_l(reset_l), .in_valid(iv && sel == 0), .in_ready(r8),
        .in_data(td[7:0]), .in_pad(pad), .in_signed(sgn), .out_valid(v8),
        .out_ready(ordy), .out_char(c8), .out_last(l8), .busy(b8)
    );

    wide_dec_fmt #(.WIDTH(64)) u64 (
        .clk(clk), .reset_l(reset_l), .in_valid(iv && sel == 1), .in_ready(r64),
        .in_data(td[63:0]), .in_pad(pad), .in_signed(sgn), .out_valid(v64),
        .out_ready(ordy), .out_char(c64), .out_last(l64), .busy(b64)
    );

    wide_dec_fmt #(.WIDTH(4096)) u4k (
        .clk(clk), .reset_l(reset_l), .in_valid(iv && sel == 2), .in_ready(r4k),
        .in_data(td), .in_pad(pad), .in_signed(sgn), .out_valid(v4k),
        .out_ready(ordy), .out_char(c4k), .out_last(l4k), .busy(b4k)
    );

    always_comb begin
        o_rdy   = sel == 0 ? r8 : sel == 1 ? r64 : r4k;
        o_valid = sel == 0 ? v8 : sel == 1 ? v64 : v4k;
        o_last  = sel == 0 ? l8 : sel == 1 ? l64 : l4k;
        o_busy  = sel == 0 ? b8 : sel == 1 ? b64 : b4k;
        o_char  = sel == 0 ? c8 : sel == 1 ? c64 : c4k;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    // Reference: printf-style decimal of the magnitude, sign prefixed, right-justified when padded
    function automatic string model(input int w, input logic [63:0] v, input bit p, input bit s);
        logic [63:0] mask, m, mag;
        bit          neg;
        string       r;
        int          cols;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        m    = v & mask;
        neg  = s && m[w-1];
        mag  = neg ? ((~m + 64'd1) & mask) : m;
        r    = $sformatf("%0d", mag);
        cols = (w == 8 ? 3 : 20) + (s ? 1 : 0);
        if (neg) r = {"-", r};
        if (p) while (r.len() < cols) r = {" ", r};
        return r;
    endfunction

    task automatic run(input int s_, input logic [4095:0] d, input bit p, input bit sg, input bit st,
                       output string got, output int first_v, output int emit_n);
        int w, nd, bound, k, cyc, last_cyc;
        bit done, pv, pr, pl;
        logic [7:0] pc;
        w     = s_ == 0 ? 8 : s_ == 1 ? 64 : 4096;
        nd    = s_ == 0 ? 3 : s_ == 1 ? 20 : 1234;
        bound = w + 8 * (nd + 2) + 50;
        sel = s_; td = d; pad = p; sgn = sg; ordy = 1'b1; iv = 1'b1;
        got = ""; first_v = -1; emit_n = -1;
        k = 0;
        while (!o_rdy && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_ready", 64'(o_rdy), 64'd1);
        @(posedge clk); #1;
        iv = 1'b0;
        cyc = 0; done = 0; pv = 0; pr = 1; pl = 0; pc = 8'h00; last_cyc = 0;
        while (!done && cyc < bound) begin
            ordy = st ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr) chk("stall_hold", 64'({o_valid, o_char, o_last}), 64'({1'b1, pc, pl}));
            if (o_valid && first_v < 0) first_v = cyc;
            if (o_valid && ordy) begin
                got = $sformatf("%s%c", got, o_char);
                if (o_last) begin
                    done = 1;
                    last_cyc = cyc;
                end
            end
            pv = o_valid; pr = ordy; pc = o_char; pl = o_last;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: sel=%0d got %0d chars, required out_last within %0d cycles", s_, got.len(), bound);
        end else begin
            emit_n = last_cyc - w + 1;
            chk("idle_after_last", 64'({o_rdy, o_busy}), 64'(2'b10));
        end
        ordy = 1'b1;
    endtask

    typedef struct {
        int          sel;
        logic [63:0] data;
        bit          pad;
        bit          sgn;
        string       exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string got, ref_s;
        int    fv, en, nd, ee;
        logic [63:0] d64;
        bit    p, g;

        vt[0]  = '{0, 64'd255, 1'b0, 1'b0, "255"};
        vt[1]  = '{0, 64'd0,   1'b0, 1'b0, "0"};
        vt[2]  = '{0, 64'd7,   1'b1, 1'b0, "  7"};
        vt[3]  = '{0, 64'hFF,  1'b1, 1'b1, "  -1"};
        vt[4]  = '{0, 64'h80,  1'b0, 1'b1, "-128"};
        vt[5]  = '{0, 64'h7F,  1'b0, 1'b1, "127"};
        vt[6]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "18446744073709551615"};
        vt[7]  = '{0, 64'd0,   1'b1, 1'b0, "  0"};
        vt[8]  = '{0, 64'h80,  1'b1, 1'b1, "-128"};
        vt[9]  = '{1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "-9223372036854775808"};
        vt[10] = '{0, 64'd5,   1'b1, 1'b1, "   5"};
        vt[11] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "-1"};

        reset_l = 1'b0; iv = 1'b0; sel = 0; td = '0; pad = 1'b0; sgn = 1'b0; ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(o_rdy), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_out_valid", 64'(o_valid), 64'd0);
        chk("rst_out_char", 64'(o_char), 64'h00);
        chk("rst_out_last", 64'(o_last), 64'd0);
        #2 reset_l = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(vt[i].sel, {4032'b0, vt[i].data}, vt[i].pad, vt[i].sgn, 1'b0, got, fv, en);
            chk_s($sformatf("vec%0d_str", i), got, vt[i].exp);
            nd = vt[i].sel == 0 ? 3 : 20;
            ee = vt[i].pad ? nd + int'(vt[i].sgn) : nd + ((vt[i].exp.len() > 0 && vt[i].exp[0] == 8'h2D) ? 1 : 0);
            chk($sformatf("vec%0d_emit_cycles", i), 64'(en), 64'(ee));
            if (vt[i].pad) chk($sformatf("vec%0d_first_valid", i), 64'(fv), vt[i].sel == 0 ? 64'd8 : 64'd64);
        end

        run(2, {4096{1'b1}}, 1'b0, 1'b0, 1'b0, got, fv, en);
        chk("w4096_len", 64'(got.len()), 64'd1234);
        chk("w4096_first_char", 64'(got.len() > 0 ? got[0] : 8'h00), 64'h31);
        chk("w4096_last_char", 64'(got.len() > 0 ? got[got.len()-1] : 8'h00), 64'h35);
        chk("w4096_first_valid", 64'(fv), 64'd4096);
        chk("w4096_emit_cycles", 64'(en), 64'd1234);

        for (int i = 0; i < 40; i++) begin
            d64 = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i % 2 == 0) d64 = d64 & (64'hFF >> $urandom_range(0, 7));
            p = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            run(i % 2, {4032'b0, d64}, p, g, 1'b1, got, fv, en);
            ref_s = model(i % 2 == 0 ? 8 : 64, d64, p, g);
            chk_s($sformatf("rand%0d_str", i), got, ref_s);
        end

        sel = 1; td = {4032'b0, 64'hFFFF_FFFF_FFFF_FFFF}; pad = 1'b0; sgn = 1'b0; ordy = 1'b1;
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (67) @(posedge clk);
        #1;
        chk("mid_emit_valid", 64'(o_valid), 64'd1);
        chk("mid_emit_busy", 64'(o_busy), 64'd1);
        reset_l = 1'b0;
        #1;
        chk("abort_out_valid", 64'(o_valid), 64'd0);
        chk("abort_out_char", 64'(o_char), 64'h00);
        chk("abort_out_last", 64'(o_last), 64'd0);
        chk("abort_in_ready", 64'({o_rdy, o_busy}), 64'(2'b10));
        @(posedge clk); #1;
        chk("abort_held_valid", 64'(o_valid), 64'd0);
        #2 reset_l = 1'b1;
        run(1, {4032'b0, 64'd42}, 1'b0, 1'b0, 1'b0, got, fv, en);
        chk_s("after_reset_42", got, "42");
        chk("after_reset_first_valid", 64'(fv), 64'd82);
        chk("after_reset_emit_cycles", 64'(en), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wide_dec_fmt.md
# wide_dec_fmt

Sequential formatter that converts a `WIDTH`-bit value to a stream of decimal ASCII characters, one per handshake, implementing `%d` (space-padded) and `%0d` (minimal) semantics for values of any width. The formatting path is table-free and does not need a wide divider. It sits between a value source, such as a wide CRC or LFSR register, and a character sink, such as a UART or test log FIFO. Optional signed mode formats two's-complement values with a leading '-'.

## Interface
- `WIDTH`, 64, input value width; 1..65536.
- `NDIG`, derived (not overridable), max decimal digits = (WIDTH*30103+99999)/100000; 64→20, 4096→1234.
- `clk`  in  1  sole clock, rising edge.
- `reset_l`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  request carries a value.
- `in_ready`  out  1  block idle, request accepted when both high.
- `in_data`  in  WIDTH  value to format.
- `in_pad`  in  1  1 = padded (`%d`), 0 = minimal (`%0d`); sampled at accept.
- `in_signed`  in  1  1 = treat `in_data` as two's complement; sampled at accept.
- `out_valid`  out  1  `out_char` valid.
- `out_ready`  in  1  sink accepts the character.
- `out_char`  out  8  ASCII character.
- `out_last`  out  1  final character of the value.
- `busy`  out  1  not in IDLE.

## Operation
- FSM: IDLE → CONV → EMIT → IDLE.
- **IDLE:** `in_ready`=1. On accept, latch the magnitude into the shift register.
  - Magnitude = `-in_data` if `in_signed` && MSB, else `in_data`.
  - Latch `neg`, `pad`, and `signed`, and clear the BCD register.
  - Go to CONV with bit counter = WIDTH.
- **CONV:** double-dabble, one bit per cycle, for exactly WIDTH cycles.
  - Each digit ≥5 gets +3, then {bcd, shreg} shifts left 1.
  - Go to EMIT at digit index NDIG-1.
  - Signed minimum, e.g. 8'h80: magnitude 128 fits unsigned WIDTH and needs no special case.
- **EMIT:** walk digit index from NDIG-1 down to 0. A digit is "leading" if it and all higher digits are 0 and the index is not 0. Digit 0 is never leading, so value 0 prints "0".
  - Minimal mode:
    - Leading digits are skipped silently at one index per cycle with `out_valid`=0.
    - If `neg`, emit '-' before the first significant digit.
  - Padded mode: every index emits one character.
    - Leading digits emit ' '.
    - If `signed`, one extra sign column precedes index NDIG-1, so total length is NDIG+1.
    - The column immediately left of the first significant digit emits '-' if `neg`; otherwise that column emits ' '.
  - Digits emit 8'h30+digit.
  - `out_last`=1 on the index-0 character. IDLE follows its accept.
- **Backpressure:** while `out_valid` && !`out_ready`, `out_char`, `out_last` and the state hold. `out_valid` never drops before accept.
- `in_valid` during CONV/EMIT is ignored; the source holds its request.

## Timing
- Reset values:
  - FSM=IDLE.
  - `in_ready`=1, `busy`=0.
  - `out_valid`=0, `out_char`=8'h00, `out_last`=0.
  - Counters 0.
- Async assert mid-CONV/EMIT aborts immediately, with no partial `out_last`. The first accept is possible on the first edge after deassert.
- Accept at edge E. CONV spans edges E+1..E+WIDTH. The first EMIT cycle follows edge E+WIDTH.
- With `out_ready`=1:
  - Padded mode: one character per cycle, no gaps.
  - Minimal mode: gaps equal to the number of skipped leading digits.
- Back-to-back: `in_ready` rises the cycle after the `out_last` accept, so there is one idle cycle minimum between values.
- `busy` = !`in_ready`.

## Structure
- Package `wide_fmt_pkg`:
  - Function `ndig(width)`.
  - FSM state enum {IDLE, CONV, EMIT}.
  - ASCII constants: CH_0=8'h30, CH_SP=8'h20, CH_MINUS=8'h2D.
- Sub-module `wide_dec_dabble`:
  - Combinational add-3 over NDIG digits, parameterised by NDIG.
  - Instantiated once in the CONV path.
- The top holds the FSM, counters, sign/pad logic and the output register.

## Test plan
- WIDTH=8, minimal, unsigned 255 → "255", `out_last` on '5'; value 0 → "0".
- WIDTH=8, padded, unsigned 7 → "  7" (3 chars); padded signed 8'hFF → "  -1" (4 chars).
- WIDTH=8, minimal, signed 8'h80 → "-128"; signed 8'h7F → "127".
- WIDTH=64, minimal, all-ones → "18446744073709551615". Randomly toggle `out_ready`: stream unchanged, chars stable while stalled.
- WIDTH=4096, minimal, all-ones → 1234 chars, first '1', last '5'. First `out_valid` 4096 cycles after accept.
- WIDTH=64, assert `reset_l` low mid-EMIT → outputs at reset values next cycle. After release, a new value 42 → "42" correctly.
